// File: rtl/multicycle_main_control.sv
// Main control FSM for the RV32I multicycle core.
// Define MC_CTRL_TRAP_EN to trap unknown opcodes instead of treating them as NOPs.
module multicycle_main_control #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [6:0]         opcode,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               adr_src,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               reg_write,
    output logic [1:0]         result_src,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic [STATE_W-1:0] state_o
`ifdef MC_CTRL_TRAP_EN
    ,
    output logic               illegal_instr
`endif
);

    if (STATE_W < 4) begin : g_bad_w
        $error("STATE_W must be >= 4");
    end

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10
`ifdef MC_CTRL_TRAP_EN
        ,
        S_TRAP     = 4'd11
`endif
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    // fetch/beq flag the states whose pc_write/ir_write depend on inputs
    typedef struct packed {
        logic       adr_src;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       pc_write;
        logic       fetch;
        logic       beq;
`ifdef MC_CTRL_TRAP_EN
        logic       illegal;
`endif
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_t;

    function automatic ctrl_t decode(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read   = 1'b1;
                c.alu_src_b  = 2'b10;
                c.result_src = 2'b10;
                c.fetch      = 1'b1;
            end
            S_DECODE: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b01;
            end
            S_MEMADR: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
            end
            S_MEMREAD: begin
                c.adr_src  = 1'b1;
                c.mem_read = 1'b1;
            end
            S_MEMWB: begin
                c.result_src = 2'b01;
                c.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                c.adr_src   = 1'b1;
                c.mem_write = 1'b1;
            end
            S_EXECR: begin
                c.alu_src_a = 2'b10;
                c.alu_op    = 2'b10;
            end
            S_EXECI: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
                c.alu_op    = 2'b10;
            end
            S_ALUWB: c.reg_write = 1'b1;
            S_JAL: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b10;
                c.pc_write  = 1'b1;
            end
            S_BEQ: begin
                c.alu_src_a = 2'b10;
                c.alu_op    = 2'b01;
                c.beq       = 1'b1;
            end
`ifdef MC_CTRL_TRAP_EN
            S_TRAP: c.illegal = 1'b1;
`endif
            default: c = '0;
        endcase
        return c;
    endfunction

    state_t state_q, state_d;
    ctrl_t  ctrl_q, ctrl_d;

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                unique case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_JAL:       state_d = S_JAL;
                    OP_BEQ:       state_d = S_BEQ;
`ifdef MC_CTRL_TRAP_EN
                    default:      state_d = S_TRAP;
`else
                    default:      state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:   state_d = (opcode == OP_LW) ? S_MEMREAD
                                                    : S_MEMWRITE;
            S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_BEQ:      state_d = S_FETCH;
`ifdef MC_CTRL_TRAP_EN
            S_TRAP:     state_d = S_TRAP;
`endif
            default:    state_d = S_FETCH;
        endcase
        ctrl_d = decode(state_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            ctrl_q  <= decode(S_FETCH);
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
        end
    end

    // FETCH strobes stay low while reset is held
    assign ir_write   = ctrl_q.fetch & mem_ready & rst_n;
    assign pc_write   = ctrl_q.pc_write | ir_write
                      | (ctrl_q.beq & zero);
    assign adr_src    = ctrl_q.adr_src;
    assign mem_read   = ctrl_q.mem_read;
    assign mem_write  = ctrl_q.mem_write;
    assign reg_write  = ctrl_q.reg_write;
    assign result_src = ctrl_q.result_src;
    assign alu_src_a  = ctrl_q.alu_src_a;
    assign alu_src_b  = ctrl_q.alu_src_b;
    assign alu_op     = ctrl_q.alu_op;
    assign state_o    = STATE_W'(state_q);
`ifdef MC_CTRL_TRAP_EN
    assign illegal_instr = ctrl_q.illegal;
`endif

endmodule

// File: tb/tb_multicycle_main_control.sv
// Scoreboard bench for multicycle_main_control.
// Expected per-cycle outputs are queued with stimulus and checked in order.
module tb_multicycle_main_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, adr_src, mem_read, mem_write;
    logic       ir_write, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
    logic [3:0] state_o;
    logic       ill;
`ifdef MC_CTRL_TRAP_EN
    logic       illegal_instr;
    assign ill = illegal_instr;
`else
    assign ill = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    multicycle_main_control #(.STATE_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode),
        .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .adr_src(adr_src),
        .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_write(reg_write),
        .result_src(result_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op),
        .state_o(state_o)
`ifdef MC_CTRL_TRAP_EN
        , .illegal_instr(illegal_instr)
`endif
    );

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, adr, mrd, mwr, irw, rgw;
        logic [1:0] rs, sa, sb, op;
        logic       ill;
    } out_t;

    typedef struct packed {
        logic       mr;
        logic       z;
        logic [6:0] opc;
        out_t       exp;
    } cyc_t;

    cyc_t sb[$];

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] JAL = 7'b1101111;
    localparam logic [6:0] BEQ = 7'b1100011;

    function automatic out_t spec_out(input int st, input logic mr,
                                      input logic z);
        out_t o;
        o = '0;
        o.st = 4'(st);
        case (st)
            0: begin
                o.mrd = 1; o.sb = 2'b10; o.rs = 2'b10;
                o.irw = mr; o.pcw = mr;
            end
            1: begin o.sa = 2'b01; o.sb = 2'b01; end
            2: begin o.sa = 2'b10; o.sb = 2'b01; end
            3: begin o.adr = 1; o.mrd = 1; end
            4: begin o.rs = 2'b01; o.rgw = 1; end
            5: begin o.adr = 1; o.mwr = 1; end
            6: begin o.sa = 2'b10; o.op = 2'b10; end
            7: begin o.sa = 2'b10; o.sb = 2'b01; o.op = 2'b10; end
            8: o.rgw = 1;
            9: begin o.sa = 2'b01; o.sb = 2'b10; o.pcw = 1; end
            10: begin o.sa = 2'b10; o.op = 2'b01; o.pcw = z; end
            11: o.ill = 1;
            default: o = '0;
        endcase
        return o;
    endfunction

    task automatic push(input int st, input logic mr, input logic z,
                        input logic [6:0] opc);
        cyc_t c;
        c.mr = mr; c.z = z; c.opc = opc;
        c.exp = spec_out(st, mr, z);
        sb.push_back(c);
    endtask

    function automatic out_t actual();
        out_t a;
        a = '{state_o, pc_write, adr_src, mem_read, mem_write,
              ir_write, reg_write, result_src, alu_src_a,
              alu_src_b, alu_op, ill};
        return a;
    endfunction

    task automatic drain(input string name);
        cyc_t c;
        out_t a;
        int n = 0;
        while (sb.size() > 0) begin
            c = sb.pop_front();
            @(negedge clk);
            opcode = c.opc; mem_ready = c.mr; zero = c.z;
            #1;
            a = actual();
            total++;
            if (a !== c.exp) begin
                bad++;
                $display("FAIL %s cyc%0d: got %h want %h",
                         name, n, a, c.exp);
            end
            n++;
        end
        @(negedge clk);
        mem_ready = 1'b0;
    endtask

    task automatic test_reset();
        out_t a;
        rst_n = 1'b0; mem_ready = 1'b1; zero = 1'b1; opcode = RT;
        repeat (2) @(posedge clk);
        #1;
        a = actual();
        total++;
        if (a !== spec_out(0, 1'b0, 1'b0)) begin
            bad++;
            $display("FAIL reset: got %h want %h",
                     a, spec_out(0, 1'b0, 1'b0));
        end
        @(negedge clk);
        mem_ready = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_rtype();
        push(0, 1, 0, RT); push(1, 1, 0, RT);
        push(6, 1, 0, RT); push(8, 1, 0, RT);
        push(0, 1, 0, IT); push(1, 0, 0, IT);
        push(7, 0, 0, IT); push(8, 0, 0, IT);
        drain("alu");
    endtask

    task automatic test_lw_stall();
        push(0, 1, 0, LW); push(1, 1, 0, LW); push(2, 1, 0, LW);
        push(3, 0, 0, LW); push(3, 0, 0, LW); push(3, 1, 0, LW);
        push(4, 0, 0, LW);
        drain("lw");
    endtask

    task automatic test_beq();
        push(0, 1, 1, BEQ); push(1, 1, 1, BEQ); push(10, 1, 1, BEQ);
        push(0, 1, 0, BEQ); push(1, 1, 0, BEQ); push(10, 1, 0, BEQ);
        drain("beq");
    endtask

    task automatic test_back_to_back();
        push(0, 0, 0, SW); push(0, 1, 0, SW); push(1, 0, 0, SW);
        push(2, 0, 0, SW); push(5, 1, 0, SW);
        push(0, 1, 0, JAL); push(1, 0, 0, JAL);
        push(9, 0, 0, JAL); push(8, 0, 0, JAL);
        push(0, 0, 0, JAL);
        drain("sw_jal");
    endtask

    task automatic test_reset_mid();
        push(0, 1, 0, SW); push(1, 1, 0, SW);
        push(2, 1, 0, SW); push(5, 0, 0, SW);
        drain("mid_pre");
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (state_o !== 4'd0 || mem_write !== 1'b0
            || mem_read !== 1'b1) begin
            bad++;
            $display("FAIL mid_rst: st=%0d mw=%b mr=%b want 0 0 1",
                     state_o, mem_write, mem_read);
        end
        @(negedge clk);
        rst_n = 1'b1;
        push(0, 1, 0, RT); push(1, 1, 0, RT);
        push(6, 1, 0, RT); push(8, 1, 0, RT);
        drain("mid_post");
    endtask

    task automatic test_illegal();
        push(0, 1, 0, 7'b0); push(1, 1, 0, 7'b0);
`ifdef MC_CTRL_TRAP_EN
        push(11, 1, 0, 7'b0); push(11, 1, 1, 7'b0);
        push(11, 0, 0, 7'b0);
        drain("trap");
        rst_n = 1'b0;
        #1;
        total++;
        if (state_o !== 4'd0 || ill !== 1'b0) begin
            bad++;
            $display("FAIL trap_rst: st=%0d ill=%b want 0 0",
                     state_o, ill);
        end
        @(negedge clk);
        rst_n = 1'b1;
        push(0, 1, 0, BEQ); push(1, 1, 0, BEQ); push(10, 1, 0, BEQ);
        drain("post_trap");
`else
        push(0, 0, 0, 7'b0); push(0, 1, 0, 7'b1111111);
        push(1, 1, 0, 7'b1111111); push(0, 0, 0, 7'b1111111);
        drain("nop");
`endif
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_stall();
        test_beq();
        test_back_to_back();
        test_reset_mid();
        test_illegal();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
